nibble_serial_adder: RTL and testbench

Multi-cycle N-bit adder/subtractor controller that time-shares one `cla4` 4-bit carry-lookahead slice. It processes one nibble per clock, LSB first, and keeps the ripple carry in a register between nibbles. Requests come in and results go out over valid/ready handshakes. It sits between the operand source (register file or test driver) and any wide-arithmetic consumer, trading latency for a single 4-bit adder's area.

---
 rtl/nibble_serial_adder_pkg.sv | 17 +
 rtl/cla4.sv | 31 +++
 rtl/nibble_serial_adder.sv | 116 +++++++++++
 tb/tb_nibble_serial_adder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor.
`default_nettype none

package nibble_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder slice.
`default_nettype none

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// N-bit adder/subtractor that reuses one cla4 slice, one nibble per clock, LSB first.
`default_nettype none

module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4*NIBBLES-1:0] req_a,
  input  logic [4*NIBBLES-1:0] req_b,
  input  logic                 req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_sum,
  output logic                 rsp_co,
  output logic                 rsp_ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t         state;
  state_t         state_nx;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   res_q;
  logic           carry_q;
  logic [IW-1:0]  idx_q;
  logic [3:0]     a_nib;
  logic [3:0]     b_nib;
  logic [3:0]     s_nib;
  logic           co_nib;
  logic           accept;
  logic           last;
  logic           done;

  assign accept = (state == IDLE) && req_valid;
  assign last   = (idx_q == LAST_IDX);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  cla4 u_cla4 (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry_q),
    .s  (s_nib),
    .co (co_nib)
  );

  // B is stored pre-inverted for subtraction so the slice only ever adds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= req_a;
      b_q     <= req_b ^ {W{req_sub == OP_SUB}};
      res_q   <= '0;
      carry_q <= (req_sub == OP_SUB);
      idx_q   <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx_q == IW'(i)) begin
          res_q[4*i +: 4] <= s_nib;
        end
      end
      carry_q <= co_nib;
      idx_q   <= idx_q + IW'(1);
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = done;
  assign rsp_sum   = done ? res_q : '0;
  assign rsp_co    = done & carry_q;
  assign rsp_ovf   = done & (a_q[W-1] == b_q[W-1]) & (res_q[W-1] != a_q[W-1]);

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard-driven directed bench for nibble_serial_adder (NIBBLES=8 and NIBBLES=1).
`default_nettype none

module tb_nibble_serial_adder;
  import nibble_serial_adder_pkg::*;

  typedef struct packed {
    logic [31:0] sum;
    logic        co;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        req_sub = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_sum;
  logic        rsp_co;
  logic        rsp_ovf;

  logic        req_valid1 = 1'b0;
  logic        req_ready1;
  logic [3:0]  req_a1 = '0;
  logic [3:0]  req_b1 = '0;
  logic        req_sub1 = 1'b0;
  logic        rsp_valid1;
  logic        rsp_ready1 = 1'b0;
  logic [3:0]  rsp_sum1;
  logic        rsp_co1;
  logic        rsp_ovf1;

  int passed = 0;
  int total  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_co(rsp_co), .rsp_ovf(rsp_ovf)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_a(req_a1), .req_b(req_b1), .req_sub(req_sub1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_sum(rsp_sum1), .rsp_co(rsp_co1), .rsp_ovf(rsp_ovf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  task automatic push_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    exp_t        e;
    logic [31:0] bb;
    logic [32:0] full;
    bb    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + 33'(sub);
    e.sum = full[31:0];
    e.co  = full[32];
    e.ovf = (a[31] == bb[31]) && (e.sum[31] != a[31]);
    sb.push_back(e);
  endtask

  // One full transaction on the 8-nibble DUT, with stray requests during RUN/DONE.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub, input int hold);
    exp_t        e;
    int          lat;
    logic [31:0] snap;
    push_model(a, b, sub);
    @(posedge clk); #1;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_a = a; req_b = b; req_sub = sub; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = ~a; req_b = 32'h5A5A_5A5A; req_sub = ~sub;
    check("req_ready_run", 32'(req_ready), 32'd0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      req_valid = (lat == 2);
      @(posedge clk); #1;
      lat++;
    end
    req_valid = 1'b0;
    check("latency", 32'(lat), 32'd8);
    snap = rsp_sum;
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_sum", rsp_sum, snap);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    check("done_req_ready", 32'(req_ready), 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sum", rsp_sum, e.sum);
      check("co", 32'(rsp_co), 32'(e.co));
      check("ovf", 32'(rsp_ovf), 32'(e.ovf));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("valid_drop", 32'(rsp_valid), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_sum"}, rsp_sum, 32'd0);
    check({tag, "_rsp_co"}, 32'(rsp_co), 32'd0);
    check({tag, "_rsp_ovf"}, 32'(rsp_ovf), 32'd0);
  endtask

  initial begin
    exp_t        e;
    int          lat;
    logic [31:0] ra;
    logic [31:0] rb;

    #3;
    check_reset_outputs("reset");
    check("reset1_req_ready", 32'(req_ready1), 32'd1);
    check("reset1_rsp_valid", 32'(rsp_valid1), 32'd0);
    #9 reset_n = 1'b1;

    do_op(32'h0000_FFFF, 32'h0000_0001, OP_ADD, 0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 0);
    do_op(32'h0000_0005, 32'h0000_0007, OP_SUB, 0);
    do_op(32'h0000_0007, 32'h0000_0005, OP_SUB, 0);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 0);
    do_op(32'h8000_0000, 32'h0000_0001, OP_SUB, 5);
    for (int r = 0; r < 3; r++) begin
      ra = $urandom;
      rb = $urandom;
      do_op(ra, rb, r[0], 1);
    end

    // Abort mid-RUN: reset lands between clock edges while nibble 3 is processed.
    @(posedge clk); #1;
    req_a = 32'hAAAA_AAAA; req_b = 32'h5555_5555; req_sub = OP_ADD; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_reset_outputs("midrun");
    #3 reset_n = 1'b1;

    do_op(32'h1234_5678, 32'h1111_1111, OP_ADD, 0);

    // Single-nibble variant: RUN lasts one cycle.
    @(posedge clk); #1;
    check("n1_req_ready", 32'(req_ready1), 32'd1);
    req_a1 = 4'hF; req_b1 = 4'h1; req_sub1 = OP_ADD; req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    lat = 0;
    while (!rsp_valid1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("n1_latency", 32'(lat), 32'd1);
    check("n1_sum", 32'(rsp_sum1), 32'h0);
    check("n1_co", 32'(rsp_co1), 32'd1);
    check("n1_ovf", 32'(rsp_ovf1), 32'd0);
    rsp_ready1 = 1'b1;
    @(posedge clk); #1;
    rsp_ready1 = 1'b0;
    check("n1_valid_drop", 32'(rsp_valid1), 32'd0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
